edge_result_packer: RTL and testbench

Sits downstream of the edge detector's result FIFO, on the FIFO-reader side. Drains 32-bit result words (one thresholded pixel in bits [15:8], end-of-frame flag in bit 0) and packs four pixels per 32-bit word for the host-bound FIFO. At end of frame it emits any partial word zero-padded, then one trailer word carrying the frame's pixel count. This cuts host-link bandwidth by 4x and gives software an explicit frame boundary.

---
 rtl/edge_pack_pkg.sv | 26 ++
 rtl/edge_pack_lanes.sv | 27 ++
 rtl/edge_result_packer.sv | 135 +++++++++++++
 tb/tb_edge_result_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pack_pkg.sv
// Shared definitions for the edge result packer: FSM encoding, trailer tag and
// result-word field layout.
package edge_pack_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_FETCH   = 2'd1;
  localparam state_t S_EMIT    = 2'd2;
  localparam state_t S_TRAILER = 2'd3;

  localparam logic [7:0] TRAILER_TAG_DEFAULT = 8'hED;

  localparam int PIX_MSB   = 15;
  localparam int PIX_LSB   = 8;
  localparam int LAST_BIT  = 0;
  localparam int PIX_CNT_W = 20;

  // Bits [31:16] and [7:1] of a result word are reserved and must be zero.
  localparam logic [31:0] RSV_MASK = 32'hFFFF_00FE;

  function automatic logic word_malformed(input logic [31:0] w);
    return (w & RSV_MASK) != 32'h0000_0000;
  endfunction

endpackage

// File: rtl/edge_pack_lanes.sv
// Four-lane byte accumulator: lane k of the output word holds the k-th pixel
// written since the last clear.
module edge_pack_lanes (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        clr,
  input  logic [1:0]  lane,
  input  logic [7:0]  pixel,
  output logic [31:0] word,
  output logic        complete
);

  // Byte-lane storage; unwritten lanes stay zero as end-of-frame padding.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= 32'h0000_0000;
    end else if (wr_en) begin
      word[{lane, 3'b000} +: 8] <= pixel;
    end else begin
      word <= word;
    end
  end

  assign complete = wr_en && (lane == 2'd3);

endmodule

// File: rtl/edge_result_packer.sv
// Drains thresholded-pixel result words, packs four pixels per host word and
// closes each frame with a tagged trailer carrying the pixel count.
module edge_result_packer
  import edge_pack_pkg::*;
#(
  parameter int         FRAME_WIDTH = 640,
  parameter logic [7:0] TRAILER_TAG = TRAILER_TAG_DEFAULT
) (
  input  logic        bus_clk,
  input  logic        rst,
  input  logic        in_fifo_result_empty,
  input  logic [31:0] in_fifo_result_dout,
  output logic        ou_fifo_result_rden,
  input  logic        in_fifo_pack_full,
  output logic        ou_fifo_pack_wren,
  output logic [31:0] ou_fifo_pack_din,
  output logic        ou_frame_done,
  output logic        ou_format_error
);

  if (FRAME_WIDTH > (1 << PIX_CNT_W)) begin : g_bad_width
    $error("FRAME_WIDTH exceeds the pixel counter range");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             lane_cnt;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic                   last_pend;
  logic                   format_error;
  logic [7:0]             pixel;
  logic                   last;
  logic                   fetch;
  logic                   lane_full;
  logic                   emit_acc;
  logic                   trl_acc;
  logic [31:0]            pack_word;

  assign pixel    = in_fifo_result_dout[PIX_MSB:PIX_LSB];
  assign last     = in_fifo_result_dout[LAST_BIT];
  assign fetch    = (state == S_FETCH);
  assign emit_acc = (state == S_EMIT) && !in_fifo_pack_full;
  assign trl_acc  = (state == S_TRAILER) && !in_fifo_pack_full;

  edge_pack_lanes u_lanes (
    .clk      (bus_clk),
    .rst      (rst),
    .wr_en    (fetch),
    .clr      (emit_acc),
    .lane     (lane_cnt),
    .pixel    (pixel),
    .word     (pack_word),
    .complete (lane_full)
  );

  // Next state and FIFO strobes; strobes are squelched while reset is held.
  always_comb begin
    state_nxt           = state;
    ou_fifo_result_rden = 1'b0;
    ou_fifo_pack_wren   = 1'b0;
    ou_fifo_pack_din    = 32'h0000_0000;
    ou_frame_done       = 1'b0;
    case (state)
      S_IDLE: begin
        ou_fifo_result_rden = !in_fifo_result_empty;
        state_nxt           = in_fifo_result_empty ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        if (lane_full || last) begin
          state_nxt = S_EMIT;
        end else begin
          ou_fifo_result_rden = !in_fifo_result_empty;
          state_nxt           = in_fifo_result_empty ? S_IDLE : S_FETCH;
        end
      end
      S_EMIT: begin
        ou_fifo_pack_din  = pack_word;
        ou_fifo_pack_wren = !in_fifo_pack_full;
        if (!in_fifo_pack_full) begin
          state_nxt = last_pend ? S_TRAILER : S_IDLE;
        end else begin
          state_nxt = S_EMIT;
        end
      end
      S_TRAILER: begin
        ou_fifo_pack_din  = {TRAILER_TAG, 4'h0, pix_cnt};
        ou_fifo_pack_wren = !in_fifo_pack_full;
        ou_frame_done     = !in_fifo_pack_full;
        state_nxt         = in_fifo_pack_full ? S_TRAILER : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (rst) begin
      ou_fifo_result_rden = 1'b0;
      ou_fifo_pack_wren   = 1'b0;
      ou_fifo_pack_din    = 32'h0000_0000;
      ou_frame_done       = 1'b0;
    end else begin
      ou_frame_done = ou_frame_done;
    end
  end

  // FSM state, lane/pixel counters and the sticky malformed-word flag.
  always_ff @(posedge bus_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lane_cnt     <= 2'd0;
      pix_cnt      <= 20'h0_0000;
      last_pend    <= 1'b0;
      format_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fetch) begin
        lane_cnt  <= lane_cnt + 2'd1;
        last_pend <= last;
        if (pix_cnt != 20'hF_FFFF) begin
          pix_cnt <= pix_cnt + 20'd1;
        end
        if (word_malformed(in_fifo_result_dout)) begin
          format_error <= 1'b1;
        end
      end else if (emit_acc) begin
        lane_cnt <= 2'd0;
      end else if (trl_acc) begin
        pix_cnt   <= 20'h0_0000;
        last_pend <= 1'b0;
      end
    end
  end

  assign ou_format_error = format_error;

endmodule

// File: tb/tb_edge_result_packer.sv
// Self-checking bench for edge_result_packer: directed frames plus randomized
// frames with random FIFO empty/full, checked against a frame-level model.
module tb_edge_result_packer;

  logic        bus_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_fifo_result_empty = 1'b1;
  logic [31:0] in_fifo_result_dout = 32'h0;
  logic        in_fifo_pack_full = 1'b0;
  logic        ou_fifo_result_rden;
  logic        ou_fifo_pack_wren;
  logic [31:0] ou_fifo_pack_din;
  logic        ou_frame_done;
  logic        ou_format_error;

  logic [31:0] src_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_in[$];
  int          stall_mode = 0;
  int          full_mode = 0;
  bit          tog = 1'b0;
  bit          rd_fire = 1'b0;
  bit          fmt_exp = 1'b0;
  int          fd_cnt = 0;
  int          rden_viol = 0;
  int          wren_viol = 0;
  int          errors = 0;
  int          checks = 0;

  edge_result_packer dut (
    .bus_clk              (bus_clk),
    .rst                  (rst),
    .in_fifo_result_empty (in_fifo_result_empty),
    .in_fifo_result_dout  (in_fifo_result_dout),
    .ou_fifo_result_rden  (ou_fifo_result_rden),
    .in_fifo_pack_full    (in_fifo_pack_full),
    .ou_fifo_pack_wren    (ou_fifo_pack_wren),
    .ou_fifo_pack_din     (ou_fifo_pack_din),
    .ou_frame_done        (ou_frame_done),
    .ou_format_error      (ou_format_error)
  );

  always #5 bus_clk = ~bus_clk;

  // Non-FWFT result FIFO and host FIFO full generator, updated just after each edge.
  always @(posedge bus_clk) begin
    #1;
    if (rd_fire) in_fifo_result_dout = src_q.pop_front();
    tog = ~tog;
    in_fifo_result_empty = (src_q.size() == 0) ||
                           (stall_mode == 1 && tog) ||
                           (stall_mode == 2 && $urandom_range(0, 2) == 0);
    in_fifo_pack_full = (full_mode == 1) || (full_mode == 2 && $urandom_range(0, 2) == 0);
  end

  // Observe the transfers that the next rising edge will perform.
  always @(negedge bus_clk) begin
    rd_fire = ou_fifo_result_rden && !in_fifo_result_empty;
    if (ou_fifo_result_rden && in_fifo_result_empty) rden_viol++;
    if (ou_fifo_pack_wren && in_fifo_pack_full) wren_viol++;
    if (ou_fifo_pack_wren && !in_fifo_pack_full) got_q.push_back(ou_fifo_pack_din);
    if (ou_frame_done) fd_cnt++;
  end

  task automatic push_word(input logic [31:0] w);
    src_q.push_back(w);
    model_in.push_back(w);
    if ((w & 32'hFFFF_00FE) != 32'h0) fmt_exp = 1'b1;
  endtask

  task automatic push_frame(input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      push_word({16'h0, p, 7'h0, (i == n - 1)});
      p = p + step;
    end
  endtask

  // Frame-level reference: split at last flags, pad to groups of four, add trailer.
  task automatic build_exp();
    logic [7:0]  pix[$];
    logic [31:0] w;
    logic [31:0] t;
    int          n;
    while (model_in.size() > 0) begin
      t = model_in.pop_front();
      pix.push_back(t[15:8]);
      if (t[0]) begin
        n = pix.size();
        for (int b = 0; b < n; b += 4) begin
          w = 32'h0;
          for (int k = 0; k < 4; k++)
            if (b + k < n) w = w | (32'(pix[b + k]) << (8 * k));
          exp_q.push_back(w);
        end
        exp_q.push_back({8'hED, 4'h0, 20'(n)});
        pix.delete();
      end
    end
  endtask

  task automatic start_case();
    got_q.delete();
    exp_q.delete();
    model_in.delete();
    fd_cnt = 0;
    rden_viol = 0;
    wren_viol = 0;
  endtask

  task automatic wait_out(input int budget);
    int idle;
    idle = 0;
    for (int c = 0; c < budget && idle < 6; c++) begin
      @(negedge bus_clk);
      if (got_q.size() >= exp_q.size() && src_q.size() == 0) idle++;
      else idle = 0;
    end
  endtask

  task automatic do_rst(input int cycles);
    @(posedge bus_clk);
    #2 rst = 1'b1;
    repeat (cycles) @(posedge bus_clk);
    #2 rst = 1'b0;
    fmt_exp = 1'b0;
  endtask

  task automatic test_reset();
    start_case();
    repeat (2) @(posedge bus_clk);
    push_word(32'h0000_5501);
    repeat (2) @(negedge bus_clk);
    checks++; if (in_fifo_result_empty !== 1'b0 || ou_fifo_result_rden !== 1'b0) begin errors++;
      $display("FAIL reset_rden: empty=%b rden=%b, required rden=0 with empty=0", in_fifo_result_empty, ou_fifo_result_rden); end
    checks++; if (ou_fifo_pack_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b need 0", ou_fifo_pack_wren); end
    checks++; if (ou_fifo_pack_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h need 0", ou_fifo_pack_din); end
    checks++; if (ou_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", ou_frame_done); end
    checks++; if (ou_format_error !== 1'b0) begin errors++; $display("FAIL reset_fmt: got %b need 0", ou_format_error); end
    @(posedge bus_clk);
    #2 rst = 1'b0;
    exp_q = '{32'h0000_0055, 32'hED00_0001};
    wait_out(200);
    checks++; if (got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL reset_first_frame_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_first_frame[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame(input string name, input int n, input logic [7:0] first,
                            input logic [7:0] step, input int smode);
    start_case();
    stall_mode = smode;
    push_frame(n, first, step);
    if (n == 8) exp_q = '{32'h4433_2211, 32'h8877_6655, 32'hED00_0008};
    else        exp_q = '{32'hA3A2_A1A0, 32'h0000_00A4, 32'hED00_0005};
    wait_out(300);
    stall_mode = 0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL %s_count: got %0d words need %0d", name, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_word[%0d]: got %h need %h", name, i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL %s_frame_done: got %0d pulses need 1", name, fd_cnt); end
    checks++; if (rden_viol != 0) begin errors++; $display("FAIL %s_rden_empty: got %0d reads while empty need 0", name, rden_viol); end
  endtask

  task automatic test_backpressure();
    start_case();
    full_mode = 1;
    push_frame(4, 8'h5A, 8'h11);
    push_word(32'h0000_3301);
    exp_q = '{32'h8D7C_6B5A, 32'hED00_0004, 32'h0000_0033, 32'hED00_0001};
    repeat (12) @(negedge bus_clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge bus_clk);
      checks++; if (ou_fifo_pack_wren !== 1'b0 || ou_fifo_result_rden !== 1'b0) begin errors++;
        $display("FAIL bp_strobes: cycle %0d wren=%b rden=%b need 0/0", c, ou_fifo_pack_wren, ou_fifo_result_rden); end
      checks++; if (ou_fifo_pack_din !== 32'h8D7C_6B5A) begin errors++;
        $display("FAIL bp_din: cycle %0d got %h need 8d7c6b5a", c, ou_fifo_pack_din); end
    end
    checks++; if (src_q.size() != 1) begin errors++; $display("FAIL bp_no_consume: %0d words left need 1", src_q.size()); end
    full_mode = 0;
    wait_out(300);
    checks++; if (got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL bp_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL bp_frame_done: got %0d need 2", fd_cnt); end
  endtask

  task automatic test_reset_midframe();
    start_case();
    push_frame(2, 8'hC1, 8'h01);
    push_word(32'h0);
    void'(src_q.pop_back());
    void'(model_in.pop_back());
    src_q[1][0] = 1'b0;
    repeat (8) @(negedge bus_clk);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_prewrite: got %0d words need 0", got_q.size()); end
    do_rst(1);
    start_case();
    push_frame(4, 8'h01, 8'h01);
    exp_q = '{32'h0403_0201, 32'hED00_0004};
    wait_out(300);
    checks++; if (got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL midrst_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_format_error();
    start_case();
    push_word(32'h0001_FF00);
    push_frame(3, 8'h01, 8'h01);
    exp_q = '{32'h0302_01FF, 32'hED00_0004};
    wait_out(300);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL fmt_word[%0d]: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end
    end
    checks++; if (ou_format_error !== fmt_exp) begin errors++; $display("FAIL fmt_set: got %b need %b", ou_format_error, fmt_exp); end
    push_frame(2, 8'h10, 8'h10);
    wait_out(300);
    checks++; if (ou_format_error !== fmt_exp) begin errors++; $display("FAIL fmt_sticky: got %b need %b", ou_format_error, fmt_exp); end
    do_rst(1);
    @(negedge bus_clk);
    checks++; if (ou_format_error !== fmt_exp) begin errors++; $display("FAIL fmt_clear: got %b need %b", ou_format_error, fmt_exp); end
  endtask

  task automatic test_random();
    int n;
    start_case();
    stall_mode = 2;
    full_mode = 2;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 13);
      for (int i = 0; i < n; i++)
        push_word({16'h0, 8'($urandom_range(0, 255)), 7'h0, (i == n - 1)});
    end
    build_exp();
    wait_out(3000);
    stall_mode = 0;
    full_mode = 0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rand_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt != 10) begin errors++; $display("FAIL rand_frame_done: got %0d need 10", fd_cnt); end
    checks++; if (rden_viol != 0 || wren_viol != 0) begin errors++;
      $display("FAIL rand_strobes: rden-while-empty %0d wren-while-full %0d need 0/0", rden_viol, wren_viol); end
    checks++; if (ou_format_error !== fmt_exp) begin errors++; $display("FAIL rand_fmt: got %b need %b", ou_format_error, fmt_exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame("basic8", 8, 8'h11, 8'h11, 0);
    test_frame("partial5", 5, 8'hA0, 8'h01, 0);
    test_backpressure();
    test_frame("empty_toggle", 8, 8'h11, 8'h11, 1);
    test_reset_midframe();
    test_format_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
